// File: rtl/pe_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pe_pkg
// Description : Shared state encoding, flag positions and default widths for
//               the PE input feeder and the PE itself.
// Revision    : 1.0 - initial release
// ============================================================================
package pe_pkg;

    localparam int c_default_element_width     = 16;
    localparam int c_default_filter_size_width = 4;
    localparam int c_default_row_len_width     = 8;
    localparam int c_default_num_rows_width    = 8;

    // Flag positions inside an IFMAP word of default element width
    localparam int SOR_BIT = c_default_element_width + 1;
    localparam int EOR_BIT = c_default_element_width;

    typedef enum logic [1:0] {
        IDLE        = 2'd0,
        LOAD_FILTER = 2'd1,
        SEND_ROW    = 2'd2,
        DONE        = 2'd3
    } feeder_state_t;

endpackage
`default_nettype wire

// File: rtl/feeder_out_reg.sv
`default_nettype none
// ============================================================================
// Module      : feeder_out_reg
// Description : Registered word-plus-write-enable output stage. The word holds
//               its last value while the enable is low.
// Revision    : 1.0 - initial release
// ============================================================================
module feeder_out_reg #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_load,
    input  logic [WIDTH-1:0] i_data,
    output logic [WIDTH-1:0] o_data,
    output logic             o_wen
);

    logic [WIDTH-1:0] r_data;
    logic             r_wen;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_data <= '0;
            r_wen  <= 1'b0;
        end else begin
            r_wen <= i_load;
            if (i_load) begin
                r_data <= i_data;
            end
        end
    end

    assign o_data = r_data;
    assign o_wen  = r_wen;

endmodule
`default_nettype wire

// File: rtl/pe_input_feeder.sv
`default_nettype none
// ============================================================================
// Module      : pe_input_feeder
// Description : Frames filter elements then flagged IFMAP rows into the PE
//               write ports, paced by the PE almost-full indications.
//               Optional FEEDER_FILTER_REUSE_EN adds reuse_filter to skip the
//               filter phase.
// Revision    : 1.0 - initial release
// ============================================================================
module pe_input_feeder
    import pe_pkg::*;
#(
    parameter int ELEMENT_WIDTH     = c_default_element_width,
    parameter int FILTER_SIZE_WIDTH = c_default_filter_size_width,
    parameter int ROW_LEN_WIDTH     = c_default_row_len_width,
    parameter int NUM_ROWS_WIDTH    = c_default_num_rows_width
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         start,
`ifdef FEEDER_FILTER_REUSE_EN
    input  logic                         reuse_filter,
`endif
    input  logic [FILTER_SIZE_WIDTH-1:0] filter_size,
    input  logic [ROW_LEN_WIDTH-1:0]     row_len,
    input  logic [NUM_ROWS_WIDTH-1:0]    num_rows,
    input  logic                         filt_valid,
    output logic                         filt_ready,
    input  logic [ELEMENT_WIDTH-1:0]     filt_data,
    input  logic                         ifmap_valid,
    output logic                         ifmap_ready,
    input  logic [ELEMENT_WIDTH-1:0]     ifmap_data,
    input  logic                         filter_full,
    input  logic                         ifmap_full,
    output logic [ELEMENT_WIDTH-1:0]     FILTER,
    output logic                         write_en_filter,
    output logic [ELEMENT_WIDTH+1:0]     IFMAP,
    output logic                         write_en_IFMAP,
    output logic                         busy,
    output logic                         done
);

    localparam logic [FILTER_SIZE_WIDTH-1:0] c_filt_one = 1;
    localparam logic [ROW_LEN_WIDTH-1:0]     c_elem_one = 1;
    localparam logic [NUM_ROWS_WIDTH-1:0]    c_row_one  = 1;

    feeder_state_t                r_state;
    logic [FILTER_SIZE_WIDTH-1:0] r_filter_size;
    logic [FILTER_SIZE_WIDTH-1:0] r_filt_cnt;
    logic [ROW_LEN_WIDTH-1:0]     r_row_len;
    logic [ROW_LEN_WIDTH-1:0]     r_elem_cnt;
    logic [NUM_ROWS_WIDTH-1:0]    r_num_rows;
    logic [NUM_ROWS_WIDTH-1:0]    r_row_cnt;
    logic                         r_busy;
    logic                         r_done;

    logic                         w_skip_filter;
    logic                         w_cfg_filter_empty;
    logic                         w_cfg_ifmap_empty;
    logic                         w_lat_ifmap_empty;
    logic                         w_filt_fire;
    logic                         w_ifmap_fire;
    logic                         w_filt_last;
    logic                         w_elem_last;
    logic                         w_row_last;
    logic                         w_sor;
    logic                         w_eor;
    logic [ELEMENT_WIDTH+1:0]     w_ifmap_word;

`ifdef FEEDER_FILTER_REUSE_EN
    assign w_skip_filter = reuse_filter;
`else
    assign w_skip_filter = 1'b0;
`endif

    // IDLE decides on the live inputs; later phases only see latched values
    assign w_cfg_filter_empty = (filter_size == '0) | w_skip_filter;
    assign w_cfg_ifmap_empty  = (row_len == '0) | (num_rows == '0);
    assign w_lat_ifmap_empty  = (r_row_len == '0) | (r_num_rows == '0);

    assign w_filt_fire  = (r_state == LOAD_FILTER) & filt_valid  & ~filter_full;
    assign w_ifmap_fire = (r_state == SEND_ROW)    & ifmap_valid & ~ifmap_full;
    assign filt_ready   = w_filt_fire;
    assign ifmap_ready  = w_ifmap_fire;

    assign w_filt_last  = (r_filt_cnt + c_filt_one) == r_filter_size;
    assign w_elem_last  = (r_elem_cnt + c_elem_one) == r_row_len;
    assign w_row_last   = (r_row_cnt + c_row_one) == r_num_rows;

    assign w_sor        = (r_elem_cnt == '0);
    assign w_eor        = w_elem_last;
    assign w_ifmap_word = {w_sor, w_eor, ifmap_data};

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state       <= IDLE;
            r_filter_size <= '0;
            r_filt_cnt    <= '0;
            r_row_len     <= '0;
            r_elem_cnt    <= '0;
            r_num_rows    <= '0;
            r_row_cnt     <= '0;
            r_busy        <= 1'b0;
            r_done        <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_filter_size <= filter_size;
                        r_row_len     <= row_len;
                        r_num_rows    <= num_rows;
                        r_filt_cnt    <= '0;
                        r_elem_cnt    <= '0;
                        r_row_cnt     <= '0;
                        r_busy        <= 1'b1;
                        if (!w_cfg_filter_empty) begin
                            r_state <= LOAD_FILTER;
                        end else if (!w_cfg_ifmap_empty) begin
                            r_state <= SEND_ROW;
                        end else begin
                            r_state <= DONE;
                            r_done  <= 1'b1;
                        end
                    end
                end
                LOAD_FILTER: begin
                    if (w_filt_fire) begin
                        if (w_filt_last) begin
                            r_filt_cnt <= '0;
                            if (w_lat_ifmap_empty) begin
                                r_state <= DONE;
                                r_done  <= 1'b1;
                            end else begin
                                r_state <= SEND_ROW;
                            end
                        end else begin
                            r_filt_cnt <= r_filt_cnt + c_filt_one;
                        end
                    end
                end
                SEND_ROW: begin
                    if (w_ifmap_fire) begin
                        if (w_elem_last) begin
                            r_elem_cnt <= '0;
                            if (w_row_last) begin
                                r_state <= DONE;
                                r_done  <= 1'b1;
                            end else begin
                                r_row_cnt <= r_row_cnt + c_row_one;
                            end
                        end else begin
                            r_elem_cnt <= r_elem_cnt + c_elem_one;
                        end
                    end
                end
                DONE: begin
                    r_state <= IDLE;
                    r_busy  <= 1'b0;
                end
                default: begin
                    r_state <= IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign busy = r_busy;
    assign done = r_done;

    feeder_out_reg #(
        .WIDTH (ELEMENT_WIDTH)
    ) u_filter_out (
        .clk    (clk),
        .rst    (rst),
        .i_load (w_filt_fire),
        .i_data (filt_data),
        .o_data (FILTER),
        .o_wen  (write_en_filter)
    );

    feeder_out_reg #(
        .WIDTH (ELEMENT_WIDTH + 2)
    ) u_ifmap_out (
        .clk    (clk),
        .rst    (rst),
        .i_load (w_ifmap_fire),
        .i_data (w_ifmap_word),
        .o_data (IFMAP),
        .o_wen  (write_en_IFMAP)
    );

endmodule
`default_nettype wire

// File: tb/tb_pe_input_feeder.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_pe_input_feeder
// Description : Directed self-checking bench for pe_input_feeder; covers the
//               reuse_filter port when FEEDER_FILTER_REUSE_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pe_input_feeder;
    import pe_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [3:0]  filter_size;
    logic [7:0]  row_len;
    logic [7:0]  num_rows;
    logic        filt_valid;
    logic        filt_ready;
    logic [15:0] filt_data;
    logic        ifmap_valid;
    logic        ifmap_ready;
    logic [15:0] ifmap_data;
    logic        filter_full;
    logic        ifmap_full;
    logic [15:0] FILTER;
    logic        write_en_filter;
    logic [17:0] IFMAP;
    logic        write_en_IFMAP;
    logic        busy;
    logic        done;
`ifdef FEEDER_FILTER_REUSE_EN
    logic        reuse_filter;
`endif

    always #5 clk = ~clk;

    pe_input_feeder dut (
        .clk             (clk),
        .rst             (rst),
        .start           (start),
`ifdef FEEDER_FILTER_REUSE_EN
        .reuse_filter    (reuse_filter),
`endif
        .filter_size     (filter_size),
        .row_len         (row_len),
        .num_rows        (num_rows),
        .filt_valid      (filt_valid),
        .filt_ready      (filt_ready),
        .filt_data       (filt_data),
        .ifmap_valid     (ifmap_valid),
        .ifmap_ready     (ifmap_ready),
        .ifmap_data      (ifmap_data),
        .filter_full     (filter_full),
        .ifmap_full      (ifmap_full),
        .FILTER          (FILTER),
        .write_en_filter (write_en_filter),
        .IFMAP           (IFMAP),
        .write_en_IFMAP  (write_en_IFMAP),
        .busy            (busy),
        .done            (done)
    );

    int          n_checks;
    int          n_fail;
    int          n_fw, n_iw, first_fw_cyc, first_iw_cyc, done_cyc, done_cnt, overlap;
    int          fidx, iidx;
    logic        done_with_fw, done_with_iw, busy_c1, busy_end;
    logic [15:0] fw [32];
    logic [17:0] iw [64];
    int          iw_cyc [64];

    // Acts as both sources (always valid, data = base + accepted index) and logs PE writes
    task automatic run_job(input logic [3:0] fsz, input logic [7:0] rlen, input logic [7:0] nrows,
                           input logic hold_filter, input int hold_at, input int hold_len,
                           input int abort_at, input logic poke);
        int   cyc;
        int   hold_cnt;
        logic w_hold, ff, fi;
        cyc = 0; hold_cnt = 0;
        n_fw = 0; n_iw = 0; first_fw_cyc = -1; first_iw_cyc = -1; done_cyc = -1;
        done_cnt = 0; overlap = 0; fidx = 0; iidx = 0;
        done_with_fw = 1'b0; done_with_iw = 1'b0; busy_c1 = 1'b0;
        filter_size = fsz; row_len = rlen; num_rows = nrows; start = 1'b1;
        filt_valid = 1'b1; ifmap_valid = 1'b1;
        while (cyc < 300) begin
            if (abort_at >= 0 && iidx == abort_at) break;
            if (done_cyc >= 0 && cyc >= done_cyc + 2) break;
            w_hold = (hold_at >= 0) && (((hold_filter ? fidx : iidx) == hold_at)) && (hold_cnt < hold_len);
            if (w_hold) hold_cnt++;
            filter_full = hold_filter & w_hold;
            ifmap_full  = ~hold_filter & w_hold;
            if (poke && cyc == 3) start = 1'b1;
            filt_data  = 16'h1000 + 16'(fidx);
            ifmap_data = 16'h2000 + 16'(iidx);
            #1;
            ff = filt_ready; fi = ifmap_ready;
            if (ff && fi) overlap++;
            @(posedge clk); #1;
            cyc++;
            start = 1'b0; filter_size = 4'hF; row_len = 8'd1; num_rows = 8'hFF;
            if (ff) fidx++;
            if (fi) iidx++;
            if (cyc == 1) busy_c1 = busy;
            if (write_en_filter) begin
                if (first_fw_cyc < 0) first_fw_cyc = cyc;
                if (n_fw < 32) fw[n_fw] = FILTER;
                n_fw++;
            end
            if (write_en_IFMAP) begin
                if (first_iw_cyc < 0) first_iw_cyc = cyc;
                if (n_iw < 64) begin iw[n_iw] = IFMAP; iw_cyc[n_iw] = cyc; end
                n_iw++;
            end
            if (done) begin
                done_cnt++;
                if (done_cyc < 0) begin
                    done_cyc = cyc; done_with_fw = write_en_filter; done_with_iw = write_en_IFMAP;
                end
            end
        end
        filter_full = 1'b0; ifmap_full = 1'b0;
        busy_end = busy;
    endtask

    task automatic test_reset();
        rst = 1'b0; filt_valid = 1'b1; ifmap_valid = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        n_checks++; if ({write_en_filter, write_en_IFMAP, busy, done} !== 4'b0) begin n_fail++; $display("FAIL reset_ctrl got %b want 0000", {write_en_filter, write_en_IFMAP, busy, done}); end
        n_checks++; if ({filt_ready, ifmap_ready} !== 2'b0) begin n_fail++; $display("FAIL reset_ready got %b want 00", {filt_ready, ifmap_ready}); end
        n_checks++; if ({FILTER, IFMAP} !== 34'h0) begin n_fail++; $display("FAIL reset_data got %h want 0", {FILTER, IFMAP}); end
        rst = 1'b1;
        @(posedge clk); #1;
        n_checks++; if ({busy, filt_ready, ifmap_ready} !== 3'b0) begin n_fail++; $display("FAIL reset_idle got %b want 000", {busy, filt_ready, ifmap_ready}); end
    endtask

    task automatic test_basic();
        logic [1:0] exp_fl [8];
        exp_fl = '{2'b10, 2'b00, 2'b00, 2'b01, 2'b10, 2'b00, 2'b00, 2'b01};
        run_job(4'd3, 8'd4, 8'd2, 1'b0, -1, 0, -1, 1'b0);
        n_checks++; if (n_fw !== 3) begin n_fail++; $display("FAIL basic_nfw got %0d want 3", n_fw); end
        n_checks++; if (first_fw_cyc !== 2) begin n_fail++; $display("FAIL basic_first_fw got %0d want 2", first_fw_cyc); end
        for (int k = 0; k < 3; k++) begin
            n_checks++; if (fw[k] !== 16'h1000 + 16'(k)) begin n_fail++; $display("FAIL basic_fw%0d got %h want %h", k, fw[k], 16'h1000 + 16'(k)); end
        end
        n_checks++; if (n_iw !== 8) begin n_fail++; $display("FAIL basic_niw got %0d want 8", n_iw); end
        n_checks++; if (first_iw_cyc !== 5) begin n_fail++; $display("FAIL basic_first_iw got %0d want 5", first_iw_cyc); end
        for (int k = 0; k < 8; k++) begin
            n_checks++; if (iw[k] !== {exp_fl[k], 16'h2000 + 16'(k)}) begin n_fail++; $display("FAIL basic_iw%0d got %h want %h", k, iw[k], {exp_fl[k], 16'h2000 + 16'(k)}); end
        end
        n_checks++; if (done_cyc !== 12) begin n_fail++; $display("FAIL basic_done_cyc got %0d want 12", done_cyc); end
        n_checks++; if ({done_with_iw, done_cnt[1:0]} !== 3'b101) begin n_fail++; $display("FAIL basic_done_pulse got %b want 101", {done_with_iw, done_cnt[1:0]}); end
        n_checks++; if ({busy_c1, busy_end} !== 2'b10) begin n_fail++; $display("FAIL basic_busy got %b want 10", {busy_c1, busy_end}); end
        n_checks++; if (overlap !== 0) begin n_fail++; $display("FAIL basic_overlap got %0d want 0", overlap); end
        n_checks++; if (iw[0][SOR_BIT] !== 1'b1 || iw[3][EOR_BIT] !== 1'b1) begin n_fail++; $display("FAIL basic_flag_pos got %b%b want 11", iw[0][SOR_BIT], iw[3][EOR_BIT]); end
    endtask

    task automatic test_row_len_one();
        // filter_full held 3 cycles before the second filter word
        run_job(4'd2, 8'd1, 8'd3, 1'b1, 1, 3, -1, 1'b0);
        n_checks++; if (n_fw !== 2) begin n_fail++; $display("FAIL r1_nfw got %0d want 2", n_fw); end
        n_checks++; if (fw[1] !== 16'h1001) begin n_fail++; $display("FAIL r1_fw1 got %h want 1001", fw[1]); end
        n_checks++; if (first_iw_cyc !== 7) begin n_fail++; $display("FAIL r1_first_iw got %0d want 7", first_iw_cyc); end
        n_checks++; if (n_iw !== 3) begin n_fail++; $display("FAIL r1_niw got %0d want 3", n_iw); end
        for (int k = 0; k < 3; k++) begin
            n_checks++; if (iw[k] !== {2'b11, 16'h2000 + 16'(k)}) begin n_fail++; $display("FAIL r1_iw%0d got %h want %h", k, iw[k], {2'b11, 16'h2000 + 16'(k)}); end
        end
        n_checks++; if (done_cyc !== 9) begin n_fail++; $display("FAIL r1_done_cyc got %0d want 9", done_cyc); end
    endtask

    task automatic test_stall();
        logic [1:0] exp_fl [8];
        exp_fl = '{2'b10, 2'b00, 2'b00, 2'b01, 2'b10, 2'b00, 2'b00, 2'b01};
        // ifmap_full held 5 cycles after the 2nd element of row 2; a stray start is poked mid-job
        run_job(4'd1, 8'd4, 8'd2, 1'b0, 6, 5, -1, 1'b1);
        n_checks++; if (n_iw !== 8) begin n_fail++; $display("FAIL stall_niw got %0d want 8", n_iw); end
        for (int k = 0; k < 8; k++) begin
            n_checks++; if (iw[k] !== {exp_fl[k], 16'h2000 + 16'(k)}) begin n_fail++; $display("FAIL stall_iw%0d got %h want %h", k, iw[k], {exp_fl[k], 16'h2000 + 16'(k)}); end
        end
        n_checks++; if (iw_cyc[5] !== 8 || iw_cyc[6] !== 14) begin n_fail++; $display("FAIL stall_gap got %0d,%0d want 8,14", iw_cyc[5], iw_cyc[6]); end
        n_checks++; if (done_cyc !== 15) begin n_fail++; $display("FAIL stall_done_cyc got %0d want 15", done_cyc); end
        n_checks++; if (n_fw !== 1 || done_cnt !== 1) begin n_fail++; $display("FAIL stall_ignore_start got nfw=%0d done=%0d want 1,1", n_fw, done_cnt); end
    endtask

    task automatic test_empty();
        run_job(4'd0, 8'd4, 8'd0, 1'b0, -1, 0, -1, 1'b0);
        n_checks++; if (done_cyc !== 1) begin n_fail++; $display("FAIL empty_done_cyc got %0d want 1", done_cyc); end
        n_checks++; if (n_fw !== 0 || n_iw !== 0) begin n_fail++; $display("FAIL empty_writes got %0d,%0d want 0,0", n_fw, n_iw); end
        n_checks++; if (done_cnt !== 1) begin n_fail++; $display("FAIL empty_done_cnt got %0d want 1", done_cnt); end
    endtask

    task automatic test_filter_only();
        run_job(4'd2, 8'd4, 8'd0, 1'b0, -1, 0, -1, 1'b0);
        n_checks++; if (n_fw !== 2 || n_iw !== 0) begin n_fail++; $display("FAIL fonly_writes got %0d,%0d want 2,0", n_fw, n_iw); end
        n_checks++; if (done_cyc !== 3 || done_with_fw !== 1'b1) begin n_fail++; $display("FAIL fonly_done got cyc=%0d wen=%b want 3,1", done_cyc, done_with_fw); end
    endtask

    task automatic test_midjob_reset();
        run_job(4'd3, 8'd4, 8'd2, 1'b0, -1, 0, 5, 1'b0);
        n_checks++; if ({busy, write_en_IFMAP} !== 2'b11) begin n_fail++; $display("FAIL mid_before got %b want 11", {busy, write_en_IFMAP}); end
        rst = 1'b0;
        #1;
        n_checks++; if ({write_en_filter, write_en_IFMAP, busy, done, filt_ready, ifmap_ready} !== 6'b0) begin n_fail++; $display("FAIL mid_rst_ctrl got %b want 000000", {write_en_filter, write_en_IFMAP, busy, done, filt_ready, ifmap_ready}); end
        n_checks++; if ({FILTER, IFMAP} !== 34'h0) begin n_fail++; $display("FAIL mid_rst_data got %h want 0", {FILTER, IFMAP}); end
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        run_job(4'd3, 8'd4, 8'd2, 1'b0, -1, 0, -1, 1'b0);
        n_checks++; if (n_fw !== 3 || fw[0] !== 16'h1000 || first_fw_cyc !== 2) begin n_fail++; $display("FAIL mid_replay_fw got n=%0d fw0=%h c=%0d want 3,1000,2", n_fw, fw[0], first_fw_cyc); end
        n_checks++; if (n_iw !== 8 || iw[0] !== {2'b10, 16'h2000} || done_cyc !== 12) begin n_fail++; $display("FAIL mid_replay_iw got n=%0d iw0=%h d=%0d want 8,22000,12", n_iw, iw[0], done_cyc); end
    endtask

`ifdef FEEDER_FILTER_REUSE_EN
    task automatic test_reuse();
        reuse_filter = 1'b1;
        run_job(4'd3, 8'd2, 8'd1, 1'b0, -1, 0, -1, 1'b0);
        reuse_filter = 1'b0;
        n_checks++; if (n_fw !== 0) begin n_fail++; $display("FAIL reuse_nfw got %0d want 0", n_fw); end
        n_checks++; if (first_iw_cyc !== 2) begin n_fail++; $display("FAIL reuse_first_iw got %0d want 2", first_iw_cyc); end
        n_checks++; if (n_iw !== 2 || iw[1] !== {2'b01, 16'h2001} || done_cyc !== 3) begin n_fail++; $display("FAIL reuse_iw got n=%0d iw1=%h d=%0d want 2,12001,3", n_iw, iw[1], done_cyc); end
    endtask
`endif

    initial begin
        n_checks = 0; n_fail = 0;
        rst = 1'b0; start = 1'b0; filter_size = '0; row_len = '0; num_rows = '0;
        filt_valid = 1'b0; ifmap_valid = 1'b0; filt_data = '0; ifmap_data = '0;
        filter_full = 1'b0; ifmap_full = 1'b0;
`ifdef FEEDER_FILTER_REUSE_EN
        reuse_filter = 1'b0;
`endif
        test_reset();
        test_basic();
        test_row_len_one();
        test_stall();
        test_empty();
        test_filter_only();
        test_midjob_reset();
`ifdef FEEDER_FILTER_REUSE_EN
        test_reuse();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
